// File: rtl/softmax_sequencer_if.sv
// Handshake and shared-arithmetic-unit bus for softmax_sequencer.
// With SOFTMAX_SEQ_ZDIV_EN defined, the bus also carries the err flag.
interface softmax_sequencer_if #(
  parameter int VLEN = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [32*VLEN-1:0]   in_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [32*VLEN-1:0]   result;
  logic                 busy;
  logic [31:0]          exp_x;
  logic [31:0]          exp_result;
  logic [31:0]          add_a;
  logic [31:0]          add_b;
  logic [31:0]          add_result;
  logic [31:0]          div_a;
  logic [31:0]          div_b;
  logic [31:0]          div_result;
  logic                 div_zero;
`ifdef SOFTMAX_SEQ_ZDIV_EN
  logic                 err;
`endif

  // Sequencer side
  modport slave (
    input  in_valid, in_vec, out_ready, exp_result, add_result, div_result, div_zero,
    output in_ready, out_valid, result, busy, exp_x, add_a, add_b, div_a, div_b
`ifdef SOFTMAX_SEQ_ZDIV_EN
    , output err
`endif
  );

  // Environment side: upstream source, downstream sink and the arithmetic units
  modport master (
    output in_valid, in_vec, out_ready, exp_result, add_result, div_result, div_zero,
    input  in_ready, out_valid, result, busy, exp_x, add_a, add_b, div_a, div_b
`ifdef SOFTMAX_SEQ_ZDIV_EN
    , input err
`endif
  );
endinterface

// File: rtl/softmax_sequencer.sv
// Time-multiplexed fp32 softmax over VLEN elements using one shared exp, adder and divider.
// Optional macro SOFTMAX_SEQ_ZDIV_EN: sticky divide-by-zero flag, zeroed results, err output.
module softmax_sequencer #(
  parameter int VLEN = 4,
  parameter int IDXW = $clog2(VLEN)
) (
  input logic               clk,
  input logic               rst_n,
  softmax_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_EXP,
    S_SUM,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(VLEN - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [IDXW-1:0]        r_idx;
  logic [IDXW-1:0]        w_idx_step;
  logic [31:0]            r_acc;
  logic [VLEN-1:0][31:0]  r_xbuf;
  logic [VLEN-1:0][31:0]  r_ebuf;
  logic [VLEN-1:0][31:0]  r_result;
  logic                   w_last;
  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_busy;
  logic [31:0]            w_exp_x;
  logic [31:0]            w_add_a;
  logic [31:0]            w_add_b;
  logic [31:0]            w_div_a;
  logic [31:0]            w_div_b;

  assign w_last     = (r_idx == LAST_IDX);
  // The phase change takes the place of the index wrap, so idx stays within 0..VLEN-1.
  assign w_idx_step = w_last ? '0 : r_idx + IDXW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_exp_x     = 32'h0;
    w_add_a     = 32'h0;
    w_add_b     = 32'h0;
    w_div_a     = 32'h0;
    w_div_b     = 32'h0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_EXP;
      end
      S_EXP: begin
        w_busy  = 1'b1;
        w_exp_x = r_xbuf[r_idx];
        if (w_last) w_next = S_SUM;
      end
      S_SUM: begin
        w_busy  = 1'b1;
        w_add_a = r_acc;
        w_add_b = r_ebuf[r_idx];
        if (w_last) w_next = S_DIV;
      end
      S_DIV: begin
        w_busy  = 1'b1;
        w_div_a = r_ebuf[r_idx];
        w_div_b = r_acc;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_acc    <= 32'h0;
      r_xbuf   <= '0;
      r_ebuf   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_xbuf <= bus.in_vec;
            r_idx  <= '0;
            r_acc  <= 32'h0;
          end
        end
        S_EXP: begin
          r_ebuf[r_idx] <= bus.exp_result;
          r_idx         <= w_idx_step;
        end
        S_SUM: begin
          r_acc <= bus.add_result;
          r_idx <= w_idx_step;
        end
        S_DIV: begin
`ifdef SOFTMAX_SEQ_ZDIV_EN
          r_result[r_idx] <= bus.div_zero ? 32'h0 : bus.div_result;
`else
          r_result[r_idx] <= bus.div_result;
`endif
          r_idx <= w_idx_step;
        end
        default: ;
      endcase
    end
  end

`ifdef SOFTMAX_SEQ_ZDIV_EN
  logic r_zflag;

  // Sticky across the DIV phase; only the output handshake or reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)                                 r_zflag <= 1'b0;
    else if (r_state == S_DIV && bus.div_zero)  r_zflag <= 1'b1;
    else if (r_state == S_DONE && bus.out_ready) r_zflag <= 1'b0;
  end

  assign bus.err = r_zflag & w_out_valid;
`else
  logic w_unused_div_zero;
  assign w_unused_div_zero = bus.div_zero;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.result    = r_result;
  assign bus.exp_x     = w_exp_x;
  assign bus.add_a     = w_add_a;
  assign bus.add_b     = w_add_b;
  assign bus.div_a     = w_div_a;
  assign bus.div_b     = w_div_b;
endmodule

// File: doc/softmax_sequencer.md
Name: softmax_sequencer

Overview:
- Time-multiplexed softmax controller: computes result[i] = exp(in[i]) / sum_j exp(in[j]) for a VLEN-element vector of IEEE-754 single-precision values.
- Uses one shared ExpFunction, one floating-point adder and one FloatingDivision instead of VLEN copies of each.
- The three units are instantiated outside this block and wired to its operand/result ports; their results are sampled in the same cycle the operands are driven.
- Sits between the layer buffer (valid/ready source) and the classifier output stage (valid/ready sink).

Parameters:
- VLEN, 4, number of 32-bit elements per vector; legal range 2..64.
- IDXW, $clog2(VLEN), width of the internal element index.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  32*VLEN  input vector; element i is in_vec[32*i+:32].
- out_valid  output  1  result vector valid.
- out_ready  input  1  sink accepts the result.
- result  output  32*VLEN  softmax probabilities; element i is result[32*i+:32].
- busy  output  1  high in EXP, SUM and DIV.
- exp_x  output  32  operand to the external ExpFunction.
- exp_result  input  32  combinational exp(exp_x).
- add_a  output  32  adder operand A.
- add_b  output  32  adder operand B.
- add_result  input  32  combinational add_a + add_b.
- div_a  output  32  divider dividend.
- div_b  output  32  divider divisor.
- div_result  input  32  combinational div_a / div_b.
- div_zero  input  1  divider zero-division flag.

Behaviour:
- Reset (rst_n=0 at an edge), from any state including mid-operation:
  - state=IDLE, idx=0, acc=0x00000000.
  - All element buffers and result cleared to 0.
  - in_ready=1, out_valid=0, busy=0, error flag 0.
  - All operand ports are 0.
- States: IDLE, EXP, SUM, DIV, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge: latch in_vec, set idx=0 and acc=0, go to EXP.
- EXP (VLEN cycles):
  - exp_x = latched element idx.
  - At each edge: ebuf[idx] <= exp_result, idx++.
  - At the edge with idx=VLEN-1: idx=0, go to SUM.
- SUM (VLEN cycles):
  - add_a = acc, add_b = ebuf[idx].
  - At each edge: acc <= add_result, idx++.
  - At idx=VLEN-1: idx=0, go to DIV.
- DIV (VLEN cycles):
  - div_a = ebuf[idx], div_b = acc.
  - At each edge: result[idx] <= div_result, idx++.
  - At idx=VLEN-1: go to DONE.
- DONE:
  - out_valid=1; result is held stable.
  - Edge with out_ready=1: out_valid=0, go to IDLE.
  - The result register keeps its value until the next DIV phase.
- Latency: a vector accepted at edge k gives out_valid=1 after edge k+3*VLEN (12 edges for VLEN=4).
- Throughput: one vector per 3*VLEN+2 cycles when out_ready is held high.
- in_ready=0 in every state except IDLE. No input skid: in_valid is ignored while not in IDLE.
- Operand ports are 0 in any state that does not use them (exp_x outside EXP, add_* outside SUM, div_* outside DIV).
- idx never exceeds VLEN-1; the phase transition replaces the wrap-around.
- in_vec is sampled only on the accepting edge; later changes to in_vec have no effect.
- div_zero is ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: SOFTMAX_SEQ_ZDIV_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - Any DIV-phase edge with div_zero=1 sets a sticky flag, and result[idx] <= 0x00000000 instead of div_result.
  - err = flag & out_valid.
  - The flag clears on the out_ready handshake and on reset.
- Undefined: no err port; div_result is always stored, including NaN/Inf produced by the divider.

Test Plan:
- VLEN=4, real units, in_vec all 0x3F800000 (1.0), out_ready=1:
  - every result element = 0x3E800000 (0.25).
  - out_valid rises exactly 12 edges after acceptance, then drops after 1 cycle.
- Backpressure: same stimulus, out_ready=0 for 5 cycles after out_valid:
  - result and out_valid stay stable; in_ready=0; a second in_valid pulse is ignored.
  - After out_ready=1: back in IDLE with in_ready=1.
- Operand sequencing: in_vec = {0,0x3F800000,0x40000000,0x40400000} (elements 0..3):
  - exp_x steps through 0x00000000, 0x3F800000, 0x40000000, 0x40400000 on consecutive EXP cycles.
  - add_a starts at 0x00000000.
  - div_b is constant across all DIV cycles.
- Reset mid-SUM: assert rst_n=0 for 1 edge at SUM idx=2:
  - next cycle in_ready=1, out_valid=0, busy=0, all operand ports 0.
  - A fresh vector then completes correctly.
- Zero division with SOFTMAX_SEQ_ZDIV_EN, exp stub returning 0x00000000 and divider stub asserting div_zero:
  - all result elements = 0x00000000.
  - err=1 with out_valid, err=0 after the handshake.
- Back-to-back: in_valid held high with two vectors, out_ready=1:
  - second accepted exactly 1 cycle after first out_valid handshake.
  - Both results correct.
